lvds_rx_word_aligner: RTL and testbench
=======================================

// Module: lvds_rx_word_aligner
// PURPOSE
// Word-alignment controller for the LVDS receive path. Sits directly downstream of the external-PLL
// LVDS deserializer, on its 8-bit parallel output (rx_out) in the slow-clock domain.
// Searches for a fixed training word and pulses the deserializer's bitslip input until the word
// lines up. It then declares lock and forwards aligned parallel data to the user logic.
// PARAMETERS
// DATA_W        8      parallel word width from the deserializer
// TRAIN_PATTERN 8'hF0  training word; all 8 rotations are distinct
// MATCH_CNT     4      consecutive matching words required to declare lock
// SLIP_WAIT     4      cycles to wait after a bitslip pulse (deserializer slip latency)
// MAX_SLIPS     8      slips tried before declaring failure (= DATA_W)
// PORTS
// clk           in   1       LVDS slow (parallel) clock; single clock domain
// reset         in   1       synchronous, active-high reset
// rx_data       in   DATA_W  deserialized word from the LVDS receiver
// align_start   in   1       1-cycle pulse: start/restart alignment from any state
// rx_bitslip    out  1       1-cycle pulse to deserializer bitslip/data_align input
// locked        out  1       alignment achieved
// align_fail    out  1       MAX_SLIPS tried without lock
// slip_count    out  4       number of slips issued in the current attempt
// aligned_data  out  DATA_W  registered rx_data; 0 when not locked
// data_valid    out  1       aligned_data valid
// BEHAVIOUR
// - All outputs are registered. Reset (sync, 1 edge) -> state IDLE; all outputs 0; internal counters 0.
// - States: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
// - align_start=1 in any state (reset not asserted): on that edge -> CHECK.
//   Clears match_cnt, slip_count, wait counter, locked, align_fail, data_valid, aligned_data, rx_bitslip.
//   align_start has priority over every other transition; reset has priority over align_start.
// - IDLE: wait for align_start; rx_data ignored.
// - CHECK: rx_data==TRAIN_PATTERN -> match_cnt++.
//   The MATCH_CNT-th consecutive match -> LOCKED; locked=1 on that same edge.
//   Mismatch with slip_count<MAX_SLIPS -> SLIP, match_cnt=0.
//   Mismatch with slip_count==MAX_SLIPS -> FAIL.
// - SLIP: rx_bitslip=1 for exactly one cycle, slip_count++, -> WAIT.
// - WAIT: rx_bitslip=0; count SLIP_WAIT cycles; then -> CHECK with match_cnt=0.
//   rx_data is not evaluated during WAIT.
//   Minimum spacing between bitslip pulses is SLIP_WAIT+2 cycles.
// - LOCKED: locked=1. aligned_data<=rx_data and data_valid<=1 every cycle.
//   First valid word appears 1 cycle after locked rises. Payload is never checked.
//   Lock is held until align_start or reset.
// - FAIL: align_fail=1, locked=0, data_valid=0; no further bitslip pulses; exit only via align_start/reset.
// - slip_count saturates at MAX_SLIPS. It holds its final value in LOCKED and FAIL.
// - Outside LOCKED: aligned_data=0, data_valid=0.
// - Reset or align_start during SLIP: any rx_bitslip pulse already high drops next edge; never stretched.
// TESTING
// Bench deserializer model: one bitslip pulse rotates the delivered word by 1 bit, effective 2 cycles later.
// 1 Reset 3 cycles, rx_data=8'hF0, no align_start -> all outputs 0, locked stays 0 for 20 cycles.
// 2 align_start, rx_data=8'hF0 already aligned -> no rx_bitslip; locked=1 on the 5th edge after start;
//   slip_count=0.
// 3 Misalignment needing 3 slips -> exactly 3 one-cycle rx_bitslip pulses, spaced >=6 cycles apart;
//   then locked=1, slip_count=3.
// 4 rx_data=8'h00 constant -> exactly 8 pulses; then align_fail=1, locked=0, slip_count=8; no more pulses.
// 5 After lock, rx_data 8'h11,8'h22,8'h44,8'h55 -> same sequence on aligned_data one cycle later,
//   data_valid=1.
// 6 reset, or align_start, asserted during WAIT and during SLIP -> counters cleared;
//   rx_bitslip=0 next cycle; realignment succeeds as in test 3.

Source files
------------

// File: rtl/lvds_rx_word_aligner.sv
// Word aligner for the LVDS deserializer's parallel output. It pulses bitslip until the
// training word lines up, then declares lock and forwards the aligned words.
module lvds_rx_word_aligner #(
    parameter int               DATA_W        = 8,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hF0,
    parameter int               MATCH_CNT     = 4,
    parameter int               SLIP_WAIT     = 4,
    parameter int               MAX_SLIPS     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              align_start,
    output logic              rx_bitslip,
    output logic              locked,
    output logic              align_fail,
    output logic [3:0]        slip_count,
    output logic [DATA_W-1:0] aligned_data,
    output logic              data_valid
);
    localparam int MC_W = $clog2(MATCH_CNT + 1);
    localparam int WC_W = $clog2(SLIP_WAIT + 1);
    localparam logic [3:0] MAX_S = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED, ST_FAIL
    } state_t;

    state_t            state, state_n;
    logic [MC_W-1:0]   match_cnt, match_n;
    logic [WC_W-1:0]   wait_cnt, wait_n;
    logic [3:0]        slip_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            match_cnt    <= '0;
            wait_cnt     <= '0;
            slip_count   <= '0;
            rx_bitslip   <= 1'b0;
            locked       <= 1'b0;
            align_fail   <= 1'b0;
            data_valid   <= 1'b0;
            aligned_data <= '0;
        end else begin
            state      <= state_n;
            match_cnt  <= match_n;
            wait_cnt   <= wait_n;
            slip_count <= slip_n;
            // Outputs follow the next state so they line up with the state they describe.
            rx_bitslip <= (state_n == ST_SLIP);
            locked     <= (state_n == ST_LOCKED);
            align_fail <= (state_n == ST_FAIL);
            // First payload word is the one after the lock edge, not the final training word.
            if (state == ST_LOCKED && state_n == ST_LOCKED) begin
                data_valid   <= 1'b1;
                aligned_data <= rx_data;
            end else begin
                data_valid   <= 1'b0;
                aligned_data <= '0;
            end
        end
    end

    always_comb begin
        state_n = state;
        match_n = match_cnt;
        wait_n  = wait_cnt;
        slip_n  = slip_count;
        if (align_start) begin
            state_n = ST_CHECK;
            match_n = '0;
            wait_n  = '0;
            slip_n  = '0;
        end else begin
            case (state)
                ST_CHECK: begin
                    if (rx_data == TRAIN_PATTERN) begin
                        match_n = match_cnt + MC_W'(1);
                        if (match_cnt == MC_W'(MATCH_CNT - 1))
                            state_n = ST_LOCKED;
                    end else if (slip_count < MAX_S) begin
                        state_n = ST_SLIP;
                        match_n = '0;
                        slip_n  = slip_count + 4'd1;
                    end else begin
                        state_n = ST_FAIL;
                        match_n = '0;
                    end
                end
                ST_SLIP: begin
                    state_n = ST_WAIT;
                    wait_n  = '0;
                end
                ST_WAIT: begin
                    if (wait_cnt == WC_W'(SLIP_WAIT - 1)) begin
                        state_n = ST_CHECK;
                        wait_n  = '0;
                        match_n = '0;
                    end else begin
                        wait_n = wait_cnt + WC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Directed bench for lvds_rx_word_aligner with a rotating-word deserializer model.
module tb_lvds_rx_word_aligner;
    localparam logic [7:0] PAT = 8'hF0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       align_start;
    logic       rx_bitslip, locked, align_fail, data_valid;
    logic [3:0] slip_count;
    logic [7:0] aligned_data;

    int checks = 0;
    int errors = 0;

    lvds_rx_word_aligner dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .align_start(align_start),
        .rx_bitslip(rx_bitslip), .locked(locked), .align_fail(align_fail),
        .slip_count(slip_count), .aligned_data(aligned_data), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    // Deserializer model: a bitslip pulse rotates the word by one bit two cycles later.
    logic       model_en = 1'b0;
    logic [7:0] rx_man = 8'h00;
    logic [2:0] rot_base = 3'd0;
    logic [2:0] model_slips = 3'd0;
    logic       slip_d = 1'b0;
    logic [2:0] cur_rot;

    function automatic logic [7:0] rol(input logic [7:0] w, input logic [2:0] r);
        logic [7:0] x;
        x = w;
        for (int i = 0; i < int'(r); i++) x = {x[6:0], x[7]};
        return x;
    endfunction

    assign cur_rot = rot_base + model_slips;
    assign rx_data = model_en ? rol(PAT, cur_rot) : rx_man;

    always @(posedge clk) begin
        slip_d <= rx_bitslip;
        if (slip_d) model_slips <= model_slips + 3'd1;
    end

    // Pulse monitor: count, width and spacing of bitslip pulses.
    logic mon_clr = 1'b1;
    int   cyc = 0, pulse_cnt = 0, last_pulse = -100, min_gap = 1000;
    bit   stretched = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            pulse_cnt = 0; last_pulse = -100; min_gap = 1000; stretched = 1'b0;
        end else if (rx_bitslip) begin
            pulse_cnt++;
            if (cyc - last_pulse == 1) stretched = 1'b1;
            else if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(input int budget);
        for (int i = 0; i < budget && !locked; i++) tick();
        chk("lock_reached", int'(locked), 1);
    endtask

    task automatic wait_pulse(input int budget);
        for (int i = 0; i < budget && !rx_bitslip; i++) tick();
        chk("pulse_seen", int'(rx_bitslip), 1);
    endtask

    task automatic set_rot(input logic [2:0] r);
        rot_base = r - model_slips;
    endtask

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] rx;
        logic       e_lock;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_slip;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[13];
    int   hi_cnt;
    int   need;

    initial begin
        // Aligned start, lock on 5th edge, payload passthrough, restart from lock, reset.
        vecs[0]  = '{0, 1, 8'hF0, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 0, 8'hF0, 0, 0, 8'h00, 0, 0};
        vecs[2]  = '{0, 0, 8'hF0, 0, 0, 8'h00, 0, 0};
        vecs[3]  = '{0, 0, 8'hF0, 0, 0, 8'h00, 0, 0};
        vecs[4]  = '{0, 0, 8'hF0, 1, 0, 8'h00, 0, 0};
        vecs[5]  = '{0, 0, 8'h11, 1, 1, 8'h11, 0, 0};
        vecs[6]  = '{0, 0, 8'h22, 1, 1, 8'h22, 0, 0};
        vecs[7]  = '{0, 0, 8'h44, 1, 1, 8'h44, 0, 0};
        vecs[8]  = '{0, 0, 8'h55, 1, 1, 8'h55, 0, 0};
        vecs[9]  = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 0};
        vecs[10] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1};
        vecs[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1};
        vecs[12] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0};

        // Reset, then idle with the training word present and no start.
        reset = 1'b1; align_start = 1'b0; rx_man = PAT;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_locked", int'(locked), 0);
        chk("rst_bitslip", int'(rx_bitslip), 0);
        chk("rst_fail", int'(align_fail), 0);
        chk("rst_slip_count", int'(slip_count), 0);
        chk("rst_data", int'(aligned_data), 0);
        chk("rst_valid", int'(data_valid), 0);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (locked || rx_bitslip || data_valid) hi_cnt++;
        end
        chk("idle_no_activity", hi_cnt, 0);

        for (int i = 0; i < 13; i++) begin
            reset = vecs[i].rst; align_start = vecs[i].start; rx_man = vecs[i].rx;
            tick();
            chk($sformatf("v%0d_locked", i), int'(locked), int'(vecs[i].e_lock));
            chk($sformatf("v%0d_valid", i), int'(data_valid), int'(vecs[i].e_valid));
            chk($sformatf("v%0d_data", i), int'(aligned_data), int'(vecs[i].e_data));
            chk($sformatf("v%0d_bitslip", i), int'(rx_bitslip), int'(vecs[i].e_slip));
            chk($sformatf("v%0d_slip_count", i), int'(slip_count), int'(vecs[i].e_cnt));
            chk($sformatf("v%0d_fail", i), int'(align_fail), 0);
        end
        reset = 1'b0; align_start = 1'b0;
        repeat (3) tick();

        // Three slips needed.
        model_en = 1'b1; set_rot(3'd5);
        mon_clr = 1'b1; align_start = 1'b1; tick();
        mon_clr = 1'b0; align_start = 1'b0;
        wait_lock(300);
        chk("s3_slip_count", int'(slip_count), 3);
        chk("s3_pulses", pulse_cnt, 3);
        chk("s3_not_stretched", int'(stretched), 0);
        chk("s3_min_gap_ge6", int'(min_gap >= 6), 1);
        chk("s3_fail", int'(align_fail), 0);

        // Constant zero: eight slips then fail, no further pulses.
        model_en = 1'b0; rx_man = 8'h00;
        mon_clr = 1'b1; align_start = 1'b1; tick();
        mon_clr = 1'b0; align_start = 1'b0;
        for (int i = 0; i < 300 && !align_fail; i++) tick();
        chk("f_align_fail", int'(align_fail), 1);
        repeat (30) tick();
        chk("f_pulses", pulse_cnt, 8);
        chk("f_slip_count", int'(slip_count), 8);
        chk("f_locked", int'(locked), 0);
        chk("f_valid", int'(data_valid), 0);
        chk("f_still_fail", int'(align_fail), 1);

        // Interrupt with reset / align_start during SLIP / WAIT, then realign.
        reset = 1'b1; tick(); reset = 1'b0;
        model_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_rot(3'd5);
            align_start = 1'b1; tick(); align_start = 1'b0;
            wait_pulse(50);
            if (k[1]) tick();
            if (k[0]) reset = 1'b1; else align_start = 1'b1;
            tick();
            reset = 1'b0; align_start = 1'b0;
            chk($sformatf("int%0d_bitslip", k), int'(rx_bitslip), 0);
            chk($sformatf("int%0d_slip_count", k), int'(slip_count), 0);
            chk($sformatf("int%0d_locked", k), int'(locked), 0);
            reset = 1'b1; repeat (3) tick(); reset = 1'b0;
            need = (8 - int'(cur_rot)) % 8;
            mon_clr = 1'b1; align_start = 1'b1; tick();
            mon_clr = 1'b0; align_start = 1'b0;
            wait_lock(300);
            chk($sformatf("int%0d_realign_count", k), int'(slip_count), need);
            chk($sformatf("int%0d_realign_pulses", k), pulse_cnt, need);
            chk($sformatf("int%0d_not_stretched", k), int'(stretched), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
